// File: rtl/branch_resolve_bht_pkg.sv
// Shared definitions for the branch resolution unit and its history table.
//   COND_*   : encodings of the id_cond branch condition field
//   SNT..ST  : 2-bit saturating direction counter states
//   cnt_step : one saturating counter move towards taken (up=1) or not taken
package branch_resolve_bht_pkg;

  localparam logic [1:0] COND_EQZ = 2'b00;
  localparam logic [1:0] COND_NEZ = 2'b01;
  localparam logic [1:0] COND_LTZ = 2'b10;
  localparam logic [1:0] COND_GEZ = 2'b11;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/bht_entry_array.sv
// Direct-mapped branch history/target storage.
//   clk, rst_n         : clock, async active-low clear (valid=0, counter=WNT)
//   rd_idx             : async read address
//   rd_valid/tag/target/cnt : contents of entry rd_idx
//   wr_en, wr_idx      : training strobe and entry index
//   wr_tag, wr_target  : tag and resolved target of the training branch
//   wr_taken           : resolved direction of the training branch
// The write port is a training port: it does its own hit check against the
// stored entry, so a second external read port is not needed.
module bht_entry_array
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_target,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic             wr_taken
);

  logic [DEPTH-1:0]            valid_q,  valid_d;
  logic [DEPTH-1:0][TAG_W-1:0] tag_q,    tag_d;
  logic [DEPTH-1:0][XLEN-1:0]  target_q, target_d;
  logic [DEPTH-1:0][1:0]       cnt_q,    cnt_d;
  logic                        wr_hit;

  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    rd_cnt    = cnt_q[rd_idx];
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    if (wr_en) begin
      if (wr_hit) begin
        cnt_d[wr_idx] = cnt_step(cnt_q[wr_idx], wr_taken);
        if (wr_taken) begin
          target_d[wr_idx] = wr_target;
        end
      end else if (wr_taken) begin
        // Taken miss evicts whatever occupies the slot; not-taken miss is ignored.
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
        cnt_d[wr_idx]    = WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a direct-mapped branch history/target table.
//   clk, rst_n              : clock, async active-low reset
//   if_pc                   : fetch PC looked up in the table
//   pred_taken, pred_target : prediction handed to IF (target 0 when not taken)
//   id_valid, id_branch     : ID holds a valid conditional branch
//   id_cond, id_reg_data    : condition code and forwarded register value
//   id_pc, id_address_field : branch PC and offset/absolute address field
//   id_pred_taken/target    : prediction that travelled with the instruction
//   pc_src, redirect_pc     : PC mux select and corrected next PC
//   if_flush, id_flush      : active-low flushes, asserted on mispredict
//   mispredict_count        : saturating count of mispredictions
// Target mode: PC_REL=0 zero-extended field<<2, PC_REL=1 id_pc+4+sext(field)<<2.
module branch_resolve_bht
  import branch_resolve_bht_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PC_REL = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic [1:0]        id_cond,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [ADDR_W-1:0] id_address_field,
  input  logic [XLEN-1:0]   id_reg_data,
  input  logic              id_pred_taken,
  input  logic [XLEN-1:0]   id_pred_target,
  output logic              pc_src,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              if_flush,
  output logic              id_flush,
  output logic [CNT_W-1:0]  mispredict_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0]         if_idx, id_idx;
  logic [TAG_W-1:0]         if_tag, id_tag;
  logic                     rd_valid;
  logic [TAG_W-1:0]         rd_tag;
  logic [XLEN-1:0]          rd_target;
  logic [1:0]               rd_cnt;
  logic                     unused_if_pc_lo;

  logic                     res, taken, mispredict;
  logic signed [ADDR_W-1:0] field_sgn;
  logic [XLEN-1:0]          field_sext, seq_pc, target;
  logic [CNT_W-1:0]         count_q, count_d;

  always_comb begin
    if_idx          = if_pc[IDX_W+1:2];
    if_tag          = if_pc[XLEN-1:IDX_W+2];
    id_idx          = id_pc[IDX_W+1:2];
    id_tag          = id_pc[XLEN-1:IDX_W+2];
    unused_if_pc_lo = ^if_pc[1:0];
  end

  bht_entry_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (if_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_cnt    (rd_cnt),
    .wr_en     (res),
    .wr_idx    (id_idx),
    .wr_tag    (id_tag),
    .wr_target (target),
    .wr_taken  (taken)
  );

  // Prediction; reset gating keeps the outputs at their reset values while rst_n is low.
  always_comb begin
    pred_taken  = rst_n && rd_valid && (rd_tag == if_tag) && rd_cnt[1];
    pred_target = pred_taken ? rd_target : '0;
  end

  // Resolution.
  always_comb begin
    res = id_valid && id_branch;
    unique case (id_cond)
      COND_EQZ: taken = (id_reg_data == '0);
      COND_NEZ: taken = (id_reg_data != '0);
      COND_LTZ: taken = id_reg_data[XLEN-1];
      default:  taken = !id_reg_data[XLEN-1];
    endcase

    field_sgn  = id_address_field;
    field_sext = XLEN'(field_sgn);
    seq_pc     = id_pc + XLEN'(4);
    if (PC_REL != 0) begin
      target = seq_pc + (field_sext << 2);
    end else begin
      target = XLEN'(id_address_field) << 2;
    end

    mispredict = res && ((taken != id_pred_taken) ||
                         (taken && id_pred_taken && (target != id_pred_target)));
  end

  always_comb begin
    pc_src      = 1'b0;
    if_flush    = 1'b1;
    id_flush    = 1'b1;
    redirect_pc = seq_pc;
    if (!rst_n) begin
      redirect_pc = '0;
    end else if (mispredict) begin
      pc_src      = 1'b1;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
      redirect_pc = taken ? target : seq_pc;
    end
  end

  always_comb begin
    count_d = count_q;
    if (mispredict && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
    mispredict_count = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;
  import branch_resolve_bht_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_branch;
  logic [1:0]  id_cond;
  logic [31:0] id_pc;
  logic [20:0] id_address_field;
  logic [31:0] id_reg_data;
  logic        id_pred_taken;
  logic [31:0] id_pred_target;

  logic        a_pred_taken, a_pc_src, a_if_flush, a_id_flush;
  logic [31:0] a_pred_target, a_redirect_pc;
  logic [1:0]  a_cnt;
  logic        r_pred_taken, r_pc_src, r_if_flush, r_id_flush;
  logic [31:0] r_pred_target, r_redirect_pc;
  logic [15:0] r_cnt;

  int checks;
  int errors;

  branch_resolve_bht #(
    .XLEN(32), .ADDR_W(21), .DEPTH(16), .PC_REL(0), .CNT_W(2)
  ) u_abs (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(a_pred_taken), .pred_target(a_pred_target),
    .id_valid(id_valid), .id_branch(id_branch), .id_cond(id_cond), .id_pc(id_pc),
    .id_address_field(id_address_field), .id_reg_data(id_reg_data),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .pc_src(a_pc_src), .redirect_pc(a_redirect_pc),
    .if_flush(a_if_flush), .id_flush(a_id_flush), .mispredict_count(a_cnt)
  );

  branch_resolve_bht #(
    .XLEN(32), .ADDR_W(21), .DEPTH(16), .PC_REL(1), .CNT_W(16)
  ) u_rel (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .pred_taken(r_pred_taken), .pred_target(r_pred_target),
    .id_valid(id_valid), .id_branch(id_branch), .id_cond(id_cond), .id_pc(id_pc),
    .id_address_field(id_address_field), .id_reg_data(id_reg_data),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .pc_src(r_pc_src), .redirect_pc(r_redirect_pc),
    .if_flush(r_if_flush), .id_flush(r_id_flush), .mispredict_count(r_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [1:0] cond,
                         input logic [31:0] data, input logic [20:0] field,
                         input logic ptk, input logic [31:0] ptgt);
    id_valid         = 1'b1;
    id_branch        = 1'b1;
    id_pc            = pc;
    id_cond          = cond;
    id_reg_data      = data;
    id_address_field = field;
    id_pred_taken    = ptk;
    id_pred_target   = ptgt;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    if_pc = 32'h40;
    id_valid = 1'b0; id_branch = 1'b0; id_cond = COND_EQZ;
    id_pc = 32'h10; id_address_field = '0; id_reg_data = '0;
    id_pred_taken = 1'b0; id_pred_target = '0;
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_pred_taken",  a_pred_taken,  1'b0);
    check("rst_pred_target", a_pred_target, 32'h0);
    check("rst_count",       a_cnt,         2'd0);
    check("rst_pc_src",      a_pc_src,      1'b0);
    check("rst_if_flush",    a_if_flush,    1'b1);
    check("rst_id_flush",    a_id_flush,    1'b1);
    check("rst_redirect",    a_redirect_pc, 32'h0);
    rst_n = 1'b1;

    // First taken branch: allocates, mispredicts, lookup same cycle sees old state.
    lookup(32'h100);
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    check("A_pc_src",   a_pc_src,      1'b1);
    check("A_redirect", a_redirect_pc, 32'h40);
    check("A_if_flush", a_if_flush,    1'b0);
    check("A_id_flush", a_id_flush,    1'b0);
    check("A_no_bypass", a_pred_taken, 1'b0);
    step();
    idle();
    check("A_pred_taken",  a_pred_taken,  1'b1);
    check("A_pred_target", a_pred_target, 32'h40);
    check("stall_pc_src",  a_pc_src,      1'b0);
    check("stall_redirect", a_redirect_pc, 32'h104);
    check("stall_if_flush", a_if_flush,   1'b1);
    check("A_count",       a_cnt,         2'd1);

    // Not taken twice: 10 -> 01 (mispredict), 01 -> 00.
    resolve(32'h100, COND_EQZ, 32'h1, 21'h10, 1'b1, 32'h40);
    check("B1_pc_src",   a_pc_src,      1'b1);
    check("B1_redirect", a_redirect_pc, 32'h104);
    step();
    idle();
    check("B1_count",       a_cnt,         2'd2);
    check("B1_pred_taken",  a_pred_taken,  1'b0);
    check("B1_pred_target", a_pred_target, 32'h0);
    resolve(32'h100, COND_EQZ, 32'h1, 21'h10, 1'b0, 32'h0);
    check("B2_pc_src",   a_pc_src,      1'b0);
    check("B2_redirect", a_redirect_pc, 32'h104);
    step();
    resolve(32'h100, COND_EQZ, 32'h1, 21'h10, 1'b0, 32'h0);
    step();
    idle();
    check("B3_pred_taken", a_pred_taken, 1'b0);

    // Taken from the floor: 00 -> 01 (still not predicted), then 01 -> 10.
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    check("C1_pc_src", a_pc_src, 1'b1);
    step();
    idle();
    check("C1_count",      a_cnt,        2'd3);
    check("C1_pred_taken", a_pred_taken, 1'b0);
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    step();
    idle();
    check("C2_count_sat",  a_cnt,        2'd3);
    check("C2_pred_taken", a_pred_taken, 1'b1);
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b1, 32'h40);
    check("C3_pc_src", a_pc_src, 1'b0);
    step();
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b1, 32'h40);
    step();
    // At 11 a not-taken only drops to 10, so the prediction stays taken.
    resolve(32'h100, COND_EQZ, 32'h1, 21'h10, 1'b1, 32'h40);
    check("C5_pc_src",   a_pc_src,      1'b1);
    check("C5_redirect", a_redirect_pc, 32'h104);
    step();
    idle();
    check("C5_count_sat",  a_cnt,        2'd3);
    check("C5_pred_taken", a_pred_taken, 1'b1);

    // Correct direction but wrong target.
    resolve(32'h100, COND_EQZ, 32'h0, 21'h20, 1'b1, 32'h40);
    check("D_pc_src",   a_pc_src,      1'b1);
    check("D_redirect", a_redirect_pc, 32'h80);
    step();
    idle();
    check("D_pred_taken",  a_pred_taken,  1'b1);
    check("D_pred_target", a_pred_target, 32'h80);

    // Condition codes, evaluated without letting a clock edge train them.
    resolve(32'h104, COND_NEZ, 32'h5, 21'h10, 1'b0, 32'h0);
    check("NEZ_t_pc_src",   a_pc_src,      1'b1);
    check("NEZ_t_redirect", a_redirect_pc, 32'h40);
    resolve(32'h104, COND_NEZ, 32'h0, 21'h10, 1'b0, 32'h0);
    check("NEZ_n_pc_src",   a_pc_src,      1'b0);
    check("NEZ_n_redirect", a_redirect_pc, 32'h108);
    resolve(32'h104, COND_LTZ, 32'h8000_0000, 21'h10, 1'b0, 32'h0);
    check("LTZ_t_pc_src", a_pc_src, 1'b1);
    idle();
    step();
    resolve(32'h104, COND_LTZ, 32'h7FFF_FFFF, 21'h10, 1'b0, 32'h0);
    check("LTZ_n_pc_src", a_pc_src, 1'b0);
    resolve(32'h104, COND_GEZ, 32'h7FFF_FFFF, 21'h10, 1'b0, 32'h0);
    check("GEZ_t_pc_src", a_pc_src, 1'b1);
    resolve(32'h104, COND_GEZ, 32'h8000_0000, 21'h10, 1'b0, 32'h0);
    check("GEZ_n_pc_src", a_pc_src, 1'b0);
    resolve(32'h104, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    id_branch = 1'b0;
    #1;
    check("nonbranch_pc_src",   a_pc_src,      1'b0);
    check("nonbranch_redirect", a_redirect_pc, 32'h108);
    idle();
    step();

    // Aliasing: 0x500 shares index 0 with 0x100 under a different tag.
    resolve(32'h500, COND_EQZ, 32'h0, 21'h30, 1'b0, 32'h0);
    check("alias_redirect", a_redirect_pc, 32'hC0);
    step();
    idle();
    lookup(32'h100);
    check("alias_evicted", a_pred_taken, 1'b0);
    lookup(32'h500);
    check("alias_pred_taken",  a_pred_taken,  1'b1);
    check("alias_pred_target", a_pred_target, 32'hC0);
    // A not-taken miss leaves the occupant alone.
    resolve(32'h100, COND_EQZ, 32'h1, 21'h10, 1'b0, 32'h0);
    check("missnt_pc_src", a_pc_src, 1'b0);
    step();
    idle();
    check("missnt_keep_taken",  a_pred_taken,  1'b1);
    check("missnt_keep_target", a_pred_target, 32'hC0);

    // Target modes: -1 field, PC-relative lands on the branch itself.
    resolve(32'h200, COND_EQZ, 32'h0, 21'h1F_FFFF, 1'b0, 32'h0);
    check("rel_pc_src",   r_pc_src,      1'b1);
    check("rel_redirect", r_redirect_pc, 32'h200);
    check("abs_zext",     a_redirect_pc, 32'h7F_FFFC);
    idle();

    // Reset asserted during a resolve: nothing written, outputs at reset values.
    resolve(32'h600, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_pc_src",      a_pc_src,      1'b0);
    check("midrst_redirect",    a_redirect_pc, 32'h0);
    check("midrst_if_flush",    a_if_flush,    1'b1);
    check("midrst_id_flush",    a_id_flush,    1'b1);
    check("midrst_count",       a_cnt,         2'd0);
    check("midrst_pred_taken",  a_pred_taken,  1'b0);
    check("midrst_pred_target", a_pred_target, 32'h0);
    step();
    rst_n = 1'b1;
    idle();
    lookup(32'h600);
    check("midrst_no_write", a_pred_taken, 1'b0);
    lookup(32'h500);
    check("midrst_cleared",  a_pred_taken, 1'b0);

    // First edge after release already trains.
    resolve(32'h100, COND_EQZ, 32'h0, 21'h10, 1'b0, 32'h0);
    step();
    idle();
    lookup(32'h100);
    check("post_rst_pred_taken",  a_pred_taken,  1'b1);
    check("post_rst_pred_target", a_pred_target, 32'h40);
    check("post_rst_count",       a_cnt,         2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
